ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, shall set the address width of all address ports.
REQ-002 Parameter DATA_W, default 8, shall set the data width of all data ports.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-006 cpu_we  in  1  CPU write (1) / read (0).
REQ-007 cpu_addr  in  ADDR_W  CPU address.
REQ-008 cpu_wdata  in  DATA_W  CPU write data.
REQ-009 cpu_ack  out  1  one-cycle completion pulse to CPU.
REQ-010 cpu_rdata  out  DATA_W  CPU read data.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata shall mirror REQ-005..010 for the debug/loader requester.
REQ-012 ram_addr  out  ADDR_W  address to RAM.
REQ-013 ram_wdata  out  DATA_W  write data to RAM.
REQ-014 ram_we  out  1  RAM write strobe.
REQ-015 ram_oe  out  1  RAM read enable.
REQ-016 ram_rdata  in  DATA_W  RAM read data, valid while ram_oe high.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 owner  out  1  current/last grantee: 0 = CPU, 1 = DBG.

Function
REQ-019 FSM states IDLE, SETUP, STROBE, ACK; transitions IDLE->SETUP (any req sampled high), SETUP->STROBE, STROBE->ACK, ACK->IDLE, all unconditional except IDLE.
REQ-020 Requests shall be sampled only in IDLE; a req rising in any other state waits for the next IDLE.
REQ-021 On grant (IDLE->SETUP edge), addr, we and wdata of the winner shall be latched; later changes to requester inputs shall be ignored for that transaction.
REQ-022 SETUP: ram_addr/ram_wdata driven from latched values, ram_we=ram_oe=0.
REQ-023 STROBE: ram_we=1 for writes, ram_oe=1 for reads, exactly one cycle; address/data stable.
REQ-024 Reads: ram_rdata captured at the STROBE->ACK edge into the winner's rdata register; rdata held until that requester's next read completes.
REQ-025 Writes shall leave both rdata registers unchanged.
REQ-026 ACK: winner's ack high exactly one cycle; the other ack stays 0.
REQ-027 Latency: req high at IDLE edge N -> ack high during cycle N+3; minimum 4 cycles between successive grants.
REQ-028 Requester shall drop req on the edge where it sees ack; req still high in the following IDLE is a new request.
REQ-029 Arbitration (both req high in IDLE): round-robin; grant goes to the requester not equal to owner; single req is granted immediately.
REQ-030 req dropped before ack: the transaction completes and ack still pulses.
REQ-031 ram_we and ram_oe shall never be high simultaneously and shall be 0 outside STROBE.
REQ-032 Address values wrap naturally modulo 2^ADDR_W; no range checking.

Reset
REQ-033 reset low shall immediately force state IDLE, owner=1 (CPU wins first contest), all acks, ram_we, ram_oe, busy = 0, ram_addr, ram_wdata, cpu_rdata, dbg_rdata = 0.
REQ-034 Reset mid-transaction shall abort without ack or RAM strobe; first cycle after release is IDLE.

Configuration
REQ-035 With macro ARB_FIXED_PRIO_EN defined, the CPU shall win every contest and owner shall not influence arbitration; without it, REQ-029 round-robin applies.

Verification
REQ-036 Reset, cpu_req=1, cpu_we=1, addr=0x10, wdata=0xA5 -> ram_we pulse cycle N+2 with ram_addr=0x10, ram_wdata=0xA5; cpu_ack cycle N+3.
REQ-037 RAM[0x10]=0xA5, dbg read 0x10 -> ram_oe cycle N+2, dbg_ack cycle N+3, dbg_rdata=0xA5; cpu_rdata unchanged.
REQ-038 Both req held continuously, reads -> grants CPU, DBG, CPU, DBG (owner 0,1,0,1); with ARB_FIXED_PRIO_EN -> CPU, CPU, CPU.
REQ-039 cpu_addr changed 0x20->0x30 during SETUP -> ram_addr stays 0x20.
REQ-040 reset asserted during STROBE of write -> ram_we falls immediately, no cpu_ack, busy=0, RAM write not counted.
REQ-041 dbg_req pulsed one cycle in IDLE then dropped -> transaction completes, dbg_ack pulses at N+3.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles the CPU, debug/loader and RAM-side signals of the
// two-requester single-port RAM arbiter. The arbiter uses the slave modport;
// the requesters/RAM environment uses the master modport.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // Debug/loader requester
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    // RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic              ram_oe;
    logic [DATA_W-1:0] ram_rdata;

    // Status
    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output ram_addr, ram_wdata, ram_we, ram_oe,
        input  ram_rdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  ram_addr, ram_wdata, ram_we, ram_oe,
        output ram_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between a CPU and a debug/loader
// requester. Each access runs IDLE -> SETUP -> STROBE -> ACK; requests are
// sampled only in IDLE and the winner's address/data are latched at grant.
// Contests are round-robin (grant to the requester that is not the current
// owner). Defining ARB_FIXED_PRIO_EN makes the CPU win every contest.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    ram_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Transaction registers, loaded on the grant edge
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Per-requester read data holding registers
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    // Combinational decode
    logic              grant_valid;
    logic              grant_dbg;
    logic              ram_we_c;
    logic              ram_oe_c;
    logic              cpu_ack_c;
    logic              dbg_ack_c;
    logic              capture_rd;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, arbitration and strobe/ack decode
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_dbg   = owner_q;
        ram_we_c    = 1'b0;
        ram_oe_c    = 1'b0;
        cpu_ack_c   = 1'b0;
        dbg_ack_c   = 1'b0;
        capture_rd  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    grant_valid = 1'b1;
                    state_d     = SETUP;
                    if (bus.cpu_req && bus.dbg_req) begin
`ifdef ARB_FIXED_PRIO_EN
                        grant_dbg = 1'b0;
`else
                        grant_dbg = ~owner_q;
`endif
                    end else begin
                        grant_dbg = bus.dbg_req;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
            end
            STROBE: begin
                ram_we_c   = we_q;
                ram_oe_c   = ~we_q;
                capture_rd = ~we_q;
                state_d    = ACK;
            end
            ACK: begin
                cpu_ack_c = ~owner_q;
                dbg_ack_c = owner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant; owner remembers the last grantee
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_valid) begin
            owner_q <= grant_dbg;
            if (grant_dbg) begin
                we_q    <= bus.dbg_we;
                addr_q  <= bus.dbg_addr;
                wdata_q <= bus.dbg_wdata;
            end else begin
                we_q    <= bus.cpu_we;
                addr_q  <= bus.cpu_addr;
                wdata_q <= bus.cpu_wdata;
            end
        end
    end

    // Capture RAM read data into the winner's register at the STROBE->ACK edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else if (capture_rd) begin
            if (owner_q) begin
                dbg_rdata_q <= bus.ram_rdata;
            end else begin
                cpu_rdata_q <= bus.ram_rdata;
            end
        end
    end

    // Strobes and acks decode from state, so reset clears them immediately
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_oe    = ram_oe_c;
    assign bus.cpu_ack   = cpu_ack_c;
    assign bus.dbg_ack   = dbg_ack_c;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed, table-driven bench for ram_arbiter with a small
// behavioural RAM attached to the RAM side of the interface.
module tb_ram_arbiter;

`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   wr_count;

    logic [7:0] mem [256];

    ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, combinational read while enabled
    assign bus.ram_rdata = bus.ram_oe ? mem[bus.ram_addr] : 8'hEE;

    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
            wr_count = wr_count + 1;
        end
    end

    typedef struct {
        bit       cr;
        bit       cw;
        bit [7:0] ca;
        bit [7:0] cd;
        bit       dr;
        bit       dw;
        bit [7:0] da;
        bit [7:0] dd;
        bit       e_owner;
        bit [7:0] e_addr;
        bit [7:0] e_wdata;
        bit       e_we;
        bit [7:0] e_crd;
        bit [7:0] e_drd;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_reqs();
        bus.cpu_req = 1'b0;
        bus.dbg_req = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        wr_count = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //       cr cw  ca     cd     dr dw  da     dd     own  addr   wdata  we  crd    drd
        vt[0] = '{1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 8'h10, 8'hA5, 1, 8'h00, 8'h00};
        vt[1] = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 1, 8'h10, 8'h00, 0, 8'h00, 8'hA5};
        vt[2] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h3C, 1, 8'h20, 8'h3C, 1, 8'h00, 8'hA5};
        vt[3] = '{1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h20, 8'h00, 0, 8'h3C, 8'hA5};
        vt[4] = '{1, 1, 8'hFF, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 8'hFF, 8'h5A, 1, 8'h3C, 8'hA5};
        // Contested reads: round-robin alternates DBG, CPU, DBG; fixed priority always CPU
        vt[5] = '{1, 0, 8'hFF, 8'h00, 1, 0, 8'h20, 8'h00,
                  FIXED ? 1'b0 : 1'b1, FIXED ? 8'hFF : 8'h20, 8'h00, 0,
                  FIXED ? 8'h5A : 8'h3C, FIXED ? 8'hA5 : 8'h3C};
        vt[6] = '{1, 0, 8'hFF, 8'h00, 1, 0, 8'h20, 8'h00,
                  0, 8'hFF, 8'h00, 0, 8'h5A, FIXED ? 8'hA5 : 8'h3C};
        vt[7] = '{1, 0, 8'hFF, 8'h00, 1, 0, 8'h10, 8'h00,
                  FIXED ? 1'b0 : 1'b1, FIXED ? 8'hFF : 8'h10, 8'h00, 0, 8'h5A, 8'hA5};

        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 8'h00;
        bus.cpu_wdata = 8'h00;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = 8'h00;
        bus.dbg_wdata = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",      32'(bus.busy),      32'(0));
        chk("rst_owner",     32'(bus.owner),     32'(1));
        chk("rst_ram_we",    32'(bus.ram_we),    32'(0));
        chk("rst_ram_oe",    32'(bus.ram_oe),    32'(0));
        chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'(0));
        chk("rst_dbg_ack",   32'(bus.dbg_ack),   32'(0));
        chk("rst_ram_addr",  32'(bus.ram_addr),  32'(0));
        chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'(0));
        chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
        chk("rst_dbg_rdata", 32'(bus.dbg_rdata), 32'(0));
        reset = 1'b1;
        cyc();

        // Table-driven transactions: request in IDLE, check SETUP/STROBE/ACK/IDLE
        for (int i = 0; i < 8; i++) begin
            bus.cpu_req   = vt[i].cr;
            bus.cpu_we    = vt[i].cw;
            bus.cpu_addr  = vt[i].ca;
            bus.cpu_wdata = vt[i].cd;
            bus.dbg_req   = vt[i].dr;
            bus.dbg_we    = vt[i].dw;
            bus.dbg_addr  = vt[i].da;
            bus.dbg_wdata = vt[i].dd;
            cyc();  // SETUP
            chk($sformatf("v%0d_setup_busy", i),  32'(bus.busy),     32'(1));
            chk($sformatf("v%0d_setup_we", i),    32'(bus.ram_we),   32'(0));
            chk($sformatf("v%0d_setup_oe", i),    32'(bus.ram_oe),   32'(0));
            chk($sformatf("v%0d_owner", i),       32'(bus.owner),    32'(vt[i].e_owner));
            chk($sformatf("v%0d_setup_addr", i),  32'(bus.ram_addr), 32'(vt[i].e_addr));
            cyc();  // STROBE
            chk($sformatf("v%0d_strobe_we", i),   32'(bus.ram_we),    32'(vt[i].e_we));
            chk($sformatf("v%0d_strobe_oe", i),   32'(bus.ram_oe),    32'(!vt[i].e_we));
            chk($sformatf("v%0d_strobe_addr", i), 32'(bus.ram_addr),  32'(vt[i].e_addr));
            chk($sformatf("v%0d_strobe_wd", i),   32'(bus.ram_wdata), 32'(vt[i].e_wdata));
            chk($sformatf("v%0d_strobe_acks", i), 32'({bus.cpu_ack, bus.dbg_ack}), 32'(0));
            cyc();  // ACK
            chk($sformatf("v%0d_cpu_ack", i),   32'(bus.cpu_ack),   32'(!vt[i].e_owner));
            chk($sformatf("v%0d_dbg_ack", i),   32'(bus.dbg_ack),   32'(vt[i].e_owner));
            chk($sformatf("v%0d_ack_we_oe", i), 32'({bus.ram_we, bus.ram_oe}), 32'(0));
            chk($sformatf("v%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vt[i].e_crd));
            chk($sformatf("v%0d_dbg_rdata", i), 32'(bus.dbg_rdata), 32'(vt[i].e_drd));
            drop_reqs();
            cyc();  // IDLE
            chk($sformatf("v%0d_idle_busy", i), 32'(bus.busy), 32'(0));
            chk($sformatf("v%0d_idle_acks", i), 32'({bus.cpu_ack, bus.dbg_ack}), 32'(0));
        end
        chk("wr_count_vectors", 32'(wr_count), 32'(3));
        chk("mem_ff", 32'(mem[8'hFF]), 32'(8'h5A));

        // Requester inputs changed after grant are ignored
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 8'h20;
        cyc();  // SETUP
        bus.cpu_addr = 8'h30;
        bus.cpu_we   = 1'b1;
        chk("latch_setup_addr", 32'(bus.ram_addr), 32'(8'h20));
        cyc();  // STROBE
        chk("latch_strobe_addr", 32'(bus.ram_addr), 32'(8'h20));
        chk("latch_strobe_oe",   32'(bus.ram_oe),   32'(1));
        chk("latch_strobe_we",   32'(bus.ram_we),   32'(0));
        cyc();  // ACK
        chk("latch_cpu_ack",   32'(bus.cpu_ack),   32'(1));
        chk("latch_cpu_rdata", 32'(bus.cpu_rdata), 32'(8'h3C));
        drop_reqs();
        bus.cpu_we = 1'b0;
        cyc();  // IDLE

        // One-cycle dbg request still completes with an ack at N+3
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 8'hFF;
        cyc();  // SETUP
        bus.dbg_req  = 1'b0;
        bus.dbg_addr = 8'h10;
        chk("pulse_setup_busy", 32'(bus.busy), 32'(1));
        chk("pulse_owner",      32'(bus.owner), 32'(1));
        cyc();  // STROBE
        chk("pulse_strobe_oe",   32'(bus.ram_oe),   32'(1));
        chk("pulse_strobe_addr", 32'(bus.ram_addr), 32'(8'hFF));
        chk("pulse_early_ack",   32'(bus.dbg_ack),  32'(0));
        cyc();  // ACK
        chk("pulse_dbg_ack",   32'(bus.dbg_ack),   32'(1));
        chk("pulse_cpu_ack",   32'(bus.cpu_ack),   32'(0));
        chk("pulse_dbg_rdata", 32'(bus.dbg_rdata), 32'(8'hFF & 8'h5A));
        cyc();  // IDLE
        chk("pulse_ack_once", 32'(bus.dbg_ack), 32'(0));
        cyc();
        chk("pulse_no_regrant", 32'(bus.busy), 32'(0));

        // Reset during the STROBE of a write aborts with no strobe, ack or RAM write
        begin
            int wc0;
            wc0 = wr_count;
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 8'h40;
            bus.cpu_wdata = 8'h77;
            cyc();  // SETUP
            cyc();  // STROBE
            chk("abort_strobe_we", 32'(bus.ram_we), 32'(1));
            #2 reset = 1'b0;
            #1;
            chk("abort_we",        32'(bus.ram_we),    32'(0));
            chk("abort_busy",      32'(bus.busy),      32'(0));
            chk("abort_cpu_ack",   32'(bus.cpu_ack),   32'(0));
            chk("abort_owner",     32'(bus.owner),     32'(1));
            chk("abort_ram_addr",  32'(bus.ram_addr),  32'(0));
            chk("abort_cpu_rdata", 32'(bus.cpu_rdata), 32'(0));
            chk("abort_dbg_rdata", 32'(bus.dbg_rdata), 32'(0));
            drop_reqs();
            bus.cpu_we = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            chk("abort_wr_count", 32'(wr_count),     32'(wc0));
            chk("abort_mem_40",   32'(mem[8'h40]),   32'(0));
            cyc();
            chk("abort_idle_busy", 32'(bus.busy), 32'(0));
            chk("abort_idle_acks", 32'({bus.cpu_ack, bus.dbg_ack}), 32'(0));
        end

        // First contest after reset goes to the CPU
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 8'h10;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 8'h20;
        cyc();  // SETUP
        chk("first_owner", 32'(bus.owner),    32'(0));
        chk("first_addr",  32'(bus.ram_addr), 32'(8'h10));
        cyc();  // STROBE
        cyc();  // ACK
        chk("first_cpu_ack",   32'(bus.cpu_ack),   32'(1));
        chk("first_dbg_ack",   32'(bus.dbg_ack),   32'(0));
        chk("first_cpu_rdata", 32'(bus.cpu_rdata), 32'(8'hA5));
        chk("first_dbg_rdata", 32'(bus.dbg_rdata), 32'(0));
        drop_reqs();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
